// File: rtl/ex_operand_stage_pkg.sv
// Shared RV32I execute-stage types, opcode constants and decode helpers.
package ex_operand_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [31:0]      instr_t;
    typedef logic [XLEN-1:0]  data_t;

    localparam data_t NULL = '0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    // addi x0,x0,0: writes x0, so the alu never commits a result for it
    localparam instr_t NOP_INSTR = 32'h00000013;

    function automatic logic [6:0] opcode_of(input instr_t i);
        return i[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input instr_t i);
        return i[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input instr_t i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input instr_t i);
        return i[24:20];
    endfunction

    // U-type and JAL carry immediate bits in the rs1 field
    function automatic logic uses_rs1(input instr_t i);
        logic [6:0] op;
        op = i[6:0];
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    // Only R, S and B formats carry a real rs2 field
    function automatic logic uses_rs2(input instr_t i);
        logic [6:0] op;
        op = i[6:0];
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Combinational source-operand select: EX/MEM result, MEM/WB result or
// the registered regfile value. x0 always reads zero.
module fwd_mux #(
    parameter int W = 32
) (
    input  logic [4:0]   rs,
    input  logic [W-1:0] rf_val,
    input  logic         exmem_rd_wr,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_data,
    input  logic         memwb_rd_wr,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_data,
    output logic [W-1:0] val
);

    // Youngest producer wins; x0 is hard-wired to zero regardless of producers
    always_comb begin
        val = rf_val;
        if (rs == 5'd0) begin
            val = '0;
        end else if (exmem_rd_wr && (exmem_rd == rs)) begin
            val = exmem_data;
        end else if (memwb_rd_wr && (memwb_rd == rs)) begin
            val = memwb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use detection, operand forwarding and
// alu operand selection for the RV32I execute stage.
module ex_operand_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_rd_wr,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            memwb_rd_wr,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data
);

    import ex_operand_stage_pkg::*;

    logic            ex_valid_q, ex_valid_d;
    logic [31:0]     ex_instr_q, ex_instr_d;
    logic [XLEN-1:0] ex_pc_q,    ex_pc_d;
    logic [XLEN-1:0] ex_imm_q,   ex_imm_d;
    logic [XLEN-1:0] ex_rs1_q,   ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q,   ex_rs2_d;

    logic            lus;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_op;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    assign ex_rd = rd_of(ex_instr_q);
    assign ex_op = opcode_of(ex_instr_q);

    // Load in EX whose rd feeds a used source of the instruction in ID.
    // Gated by rst so the request drops as soon as reset is applied.
    always_comb begin
        lus = 1'b0;
        if (!rst && !flush && ex_valid_q && (ex_op == OP_LOAD) &&
            (ex_rd != 5'd0) && id_valid) begin
            lus = ((rs1_of(id_instr) == ex_rd) && uses_rs1(id_instr)) ||
                  ((rs2_of(id_instr) == ex_rd) && uses_rs2(id_instr));
        end
    end

    // Next EX contents: flush > load-use bubble > hold > load (id_valid=0 loads a bubble)
    always_comb begin
        ex_valid_d = 1'b0;
        ex_instr_d = NOP_INSTR;
        ex_pc_d    = '0;
        ex_imm_d   = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        if (flush || lus) begin
            ex_valid_d = 1'b0;
        end else if (stall) begin
            ex_valid_d = ex_valid_q;
            ex_instr_d = ex_instr_q;
            ex_pc_d    = ex_pc_q;
            ex_imm_d   = ex_imm_q;
            ex_rs1_d   = ex_rs1_q;
            ex_rs2_d   = ex_rs2_q;
        end else if (id_valid) begin
            ex_valid_d = 1'b1;
            ex_instr_d = id_instr;
            ex_pc_d    = id_pc;
            ex_imm_d   = id_imm;
            ex_rs1_d   = id_rs1_data;
            ex_rs2_d   = id_rs2_data;
        end
    end

    // ID/EX register; reset clears everything to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= NOP_INSTR;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            ex_pc_q    <= ex_pc_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
        end
    end

    fwd_mux #(.W(XLEN)) u_fwd_rs1 (
        .rs          (rs1_of(ex_instr_q)),
        .rf_val      (ex_rs1_q),
        .exmem_rd_wr (exmem_rd_wr),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_rd_wr (memwb_rd_wr),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .val         (rs1_fwd)
    );

    fwd_mux #(.W(XLEN)) u_fwd_rs2 (
        .rs          (rs2_of(ex_instr_q)),
        .rf_val      (ex_rs2_q),
        .exmem_rd_wr (exmem_rd_wr),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_rd_wr (memwb_rd_wr),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .val         (rs2_fwd)
    );

    // alu operands: PC-relative/link forms take the PC, LUI adds to zero
    always_comb begin
        alu_a = rs1_fwd;
        if (ex_op == OP_AUIPC || ex_op == OP_JAL || ex_op == OP_JALR) begin
            alu_a = ex_pc_q;
        end else if (ex_op == OP_LUI) begin
            alu_a = '0;
        end
        alu_b = ex_imm_q;
        if (ex_op == OP_R || ex_op == OP_BRANCH) begin
            alu_b = rs2_fwd;
        end
    end

    assign load_use_stall = lus;
    assign ex_valid       = ex_valid_q;
    assign ex_instr       = ex_instr_q;
    assign ex_pc          = ex_pc_q;
    assign ex_store_data  = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus a randomized run,
// all checked against an architectural model of the ID/EX slot.
module tb_ex_operand_stage;

    localparam logic [6:0] T_LOAD = 7'h03, T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6f,
                           T_JALR = 7'h67, T_BR = 7'h63, T_ST = 7'h23, T_R = 7'h33, T_I = 7'h13;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst, id_valid, stall, flush, exmem_rd_wr, memwb_rd_wr;
    logic [31:0] id_instr, id_pc, id_imm, id_rs1_data, id_rs2_data, exmem_data, memwb_data;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        load_use_stall, ex_valid;
    logic [31:0] ex_instr, ex_pc, alu_a, alu_b, ex_store_data;

    int errors = 0;
    int checks = 0;

    // Model of the EX slot contents
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_imm, m_r1, m_r2;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stall(stall), .flush(flush), .exmem_rd_wr(exmem_rd_wr), .exmem_rd(exmem_rd),
        .exmem_data(exmem_data), .memwb_rd_wr(memwb_rd_wr), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        logic [4:0] d, a, b;
        d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
        return {7'd0, b, a, 3'd0, d, T_R};
    endfunction

    // Value the architecture says register rs holds at this moment
    function automatic logic [31:0] arch_reg(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (exmem_rd_wr && exmem_rd == rs) return exmem_data;
        if (memwb_rd_wr && memwb_rd == rs) return memwb_data;
        return rf;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] i);
        return !(i[6:0] inside {T_LUI, T_AUIPC, T_JAL});
    endfunction

    function automatic bit reads_rs2(input logic [31:0] i);
        return i[6:0] inside {T_R, T_ST, T_BR};
    endfunction

    function automatic logic exp_lus();
        logic [4:0] rd;
        rd = m_instr[11:7];
        if (rst || flush || !m_valid || m_instr[6:0] != T_LOAD || rd == 0 || !id_valid) return 1'b0;
        return (id_instr[19:15] == rd && reads_rs1(id_instr)) ||
               (id_instr[24:20] == rd && reads_rs2(id_instr));
    endfunction

    function automatic logic [31:0] exp_a();
        case (m_instr[6:0])
            T_AUIPC, T_JAL, T_JALR: return m_pc;
            T_LUI:                  return 32'd0;
            default:                return arch_reg(m_instr[19:15], m_r1);
        endcase
    endfunction

    function automatic logic [31:0] exp_b();
        if (m_instr[6:0] inside {T_R, T_BR}) return arch_reg(m_instr[24:20], m_r2);
        return m_imm;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_instr = NOP; m_pc = 0; m_imm = 0; m_r1 = 0; m_r2 = 0;
    endtask

    task automatic check_model();
        chk("m_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("m_instr", ex_instr, m_instr);
        chk("m_pc", ex_pc, m_pc);
        chk("m_alu_a", alu_a, exp_a());
        chk("m_alu_b", alu_b, exp_b());
        chk("m_store", ex_store_data, arch_reg(m_instr[24:20], m_r2));
        chk("m_lus", {31'd0, load_use_stall}, {31'd0, exp_lus()});
    endtask

    // Check the current cycle, then advance one edge and update the model
    task automatic step();
        logic lu;
        #2;
        check_model();
        lu = exp_lus();
        @(posedge clk);
        if (rst || flush || lu) model_bubble();
        else if (stall) ;
        else if (id_valid) begin
            m_valid = 1; m_instr = id_instr; m_pc = id_pc; m_imm = id_imm;
            m_r1 = id_rs1_data; m_r2 = id_rs2_data;
        end else model_bubble();
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 0; id_valid = 0; id_instr = NOP; id_pc = 0; id_imm = 0;
        id_rs1_data = 0; id_rs2_data = 0; stall = 0; flush = 0;
        exmem_rd_wr = 0; exmem_rd = 0; exmem_data = 0;
        memwb_rd_wr = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        id_valid = 1; id_instr = instr; id_pc = pc; id_imm = 32'h4;
        id_rs1_data = r1; id_rs2_data = r2;
        step();
        id_valid = 0; id_instr = NOP;
    endtask

    initial begin
        logic [31:0] lw_x5, add_dep, lui_x6;
        logic [6:0]  ops [9];
        lw_x5   = {12'd0, 5'd1, 3'b010, 5'd5, T_LOAD};
        add_dep = enc_r(6, 5, 4);
        lui_x6  = {20'd1, 5'd6, T_LUI};
        ops = '{T_LOAD, T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_ST, T_R, T_I};

        quiet_inputs();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        model_bubble();

        // Reset state
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_instr", ex_instr, NOP);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_lus", {31'd0, load_use_stall}, 32'd0);
        step();
        rst = 0;
        step();

        // add x3,x1,x2 with no forwarding
        load(enc_r(3, 1, 2), 32'h10, 32'd5, 32'd7);
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_sum", alu_a + alu_b, 32'd12);

        // EX/MEM beats MEM/WB; MEM/WB used when EX/MEM targets x0
        exmem_rd_wr = 1; exmem_rd = 1; exmem_data = 32'h100;
        memwb_rd_wr = 1; memwb_rd = 1; memwb_data = 32'h200;
        #1 chk("fwd_exmem", alu_a, 32'h100);
        exmem_rd = 0;
        #1 chk("fwd_memwb", alu_a, 32'h200);
        step();
        quiet_inputs();

        // x0 source is never forwarded
        load(enc_r(3, 0, 2), 32'h14, 32'h55, 32'd9);
        exmem_rd_wr = 1; exmem_rd = 0; exmem_data = 32'hDEAD;
        #1 chk("x0_a", alu_a, 32'd0);
        step();
        quiet_inputs();

        // Load-use: lw x5 in EX, add x6,x5,x4 in ID
        load(lw_x5, 32'h20, 32'h1000, 32'd0);
        id_valid = 1; id_instr = add_dep;
        #1 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_instr", ex_instr, NOP);
        chk("lu_drop", {31'd0, load_use_stall}, 32'd0);
        step();
        quiet_inputs();

        // lui in ID does not read x5
        load(lw_x5, 32'h24, 32'h1000, 32'd0);
        id_valid = 1; id_instr = lui_x6;
        #1 chk("lu_lui", {31'd0, load_use_stall}, 32'd0);
        quiet_inputs();
        step();

        // Flush overrides stall and load-use
        load(lw_x5, 32'h28, 32'h1000, 32'd0);
        id_valid = 1; id_instr = add_dep; stall = 1; flush = 1;
        #1 chk("fl_lus", {31'd0, load_use_stall}, 32'd0);
        step();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_instr", ex_instr, NOP);
        quiet_inputs();

        // Stall holds EX while ID changes, then reset mid-stall
        load(enc_r(3, 1, 2), 32'h40, 32'd11, 32'd22);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_instr = $urandom; id_pc = $urandom; id_imm = $urandom;
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            step();
            chk("st_a", alu_a, 32'd11);
            chk("st_b", alu_b, 32'd22);
            chk("st_pc", ex_pc, 32'h40);
        end
        rst = 1;
        step();
        chk("st_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("st_rst_instr", ex_instr, NOP);
        chk("st_rst_pc", ex_pc, 32'd0);
        quiet_inputs();

        // Reset drops a pending load-use request immediately
        load(lw_x5, 32'h50, 32'h1000, 32'd0);
        id_valid = 1; id_instr = add_dep;
        #1 chk("lu_pre_rst", {31'd0, load_use_stall}, 32'd1);
        rst = 1;
        #1 chk("lu_rst", {31'd0, load_use_stall}, 32'd0);
        step();
        quiet_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = {$urandom_range(127, 0) > 0 ? 7'($urandom) : 7'd0,
                   5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 3'($urandom),
                   5'($urandom_range(7, 0)), ops[$urandom_range(8, 0)]};
            rst         = ($urandom_range(63, 0) == 0);
            flush       = ($urandom_range(15, 0) == 0);
            stall       = ($urandom_range(7, 0) == 0);
            id_valid    = ($urandom_range(3, 0) != 0);
            id_instr    = ins;
            id_pc       = $urandom; id_imm = $urandom;
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            exmem_rd_wr = 1'($urandom); exmem_rd = 5'($urandom_range(7, 0)); exmem_data = $urandom;
            memwb_rd_wr = 1'($urandom); memwb_rd = 5'($urandom_range(7, 0)); memwb_data = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
